// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises a fetch port and a data port onto one
// busywait-style main memory. Address and write data are captured at grant,
// read data is returned through registered per-port outputs, and a hung
// memory is released after TIMEOUT wait cycles with a sticky ERROR flag.
// Optional build macro: ROUND_ROBIN_EN (alternating priority between the
// two requesters; the default build gives data fixed priority over fetch).
module mem_arbiter #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 31
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT,
  output logic              ERROR
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RELEASE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

  // Last wait cycle before the access is abandoned.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  owner_t     owner, owner_nxt;
  logic [7:0] count, count_nxt;
  logic       d_req;
  logic       prefer_i;
  logic       grant_i, grant_d;
  logic       mem_done, time_out;

  assign d_req = D_READ | D_WRITE;

  // The owner is released only during its single RELEASE cycle.
  assign I_BUSYWAIT = I_READ & ~(state == S_RELEASE && owner == OWN_I);
  assign D_BUSYWAIT = d_req  & ~(state == S_RELEASE && owner == OWN_D);

`ifdef ROUND_ROBIN_EN
  logic prio_i;

  // Priority goes to the requester that was not served by the last access.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      prio_i <= 1'b0;
    else if (mem_done || time_out)
      prio_i <= (owner == OWN_D);
  end

  assign prefer_i = prio_i;
`else
  assign prefer_i = 1'b0;
`endif

  // State register: FSM state, current owner and wait-cycle counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
      owner <= OWN_NONE;
      count <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state <= state_nxt;
      owner <= owner_nxt;
      count <= count_nxt;
    end
  end

  // Next-state logic: arbitration, wait counting and completion detection.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    state_nxt = state;
    owner_nxt = owner;
    count_nxt = count;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    mem_done  = 1'b0;
    time_out  = 1'b0;
    unique case (state)
      S_IDLE: begin
        // A still-busy memory (aborted op) must finish before a new grant.
        if (!MEM_BUSYWAIT) begin
          grant_d = d_req & ~(I_READ & prefer_i);
          grant_i = I_READ & ~grant_d;
          if (grant_d) begin
            owner_nxt = OWN_D;
            state_nxt = S_ISSUE;
          end else if (grant_i) begin
            owner_nxt = OWN_I;
            state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        state_nxt = S_WAIT;
        count_nxt = '0;
      end
      S_WAIT: begin
        if (!MEM_BUSYWAIT) begin
          mem_done  = 1'b1;
          state_nxt = S_RELEASE;
        end else if (count == TIMEOUT_LAST) begin
          time_out  = 1'b1;
          state_nxt = S_RELEASE;
        end else begin
          count_nxt = count + 8'd1;
        end
      end
      S_RELEASE: begin
        owner_nxt = OWN_NONE;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: memory strobes and operands, returned read data, error flag.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
      I_READDATA    <= '0;
      D_READDATA    <= '0;
      ERROR         <= 1'b0;
    end else begin
      if (grant_d) begin
        // A simultaneous read and write request is served as a write.
        MEM_WRITE     <= D_WRITE;
        MEM_READ      <= ~D_WRITE;
        MEM_ADDRESS   <= D_ADDRESS;
        MEM_WRITEDATA <= D_WRITEDATA;
      end else if (grant_i) begin
        MEM_READ    <= 1'b1;
        MEM_WRITE   <= 1'b0;
        MEM_ADDRESS <= I_ADDRESS;
      end
      if (mem_done || time_out) begin
        MEM_READ  <= 1'b0;
        MEM_WRITE <= 1'b0;
      end
      if (mem_done && MEM_READ) begin
        if (owner == OWN_I)
          I_READDATA <= MEM_READDATA;
        else
          D_READDATA <= MEM_READDATA;
      end
      if (time_out)
        ERROR <= 1'b1;
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences one shared main memory between two requesters: the instruction fetch port and the CPU data-access port.
- Both requesters use the busywait handshake already used by the CPU. Requesters sit on one side; the main memory (busywait-style, multi-cycle) sits on the other.
- Serialises accesses, latches address and write data at grant, returns read data, and flags a hung memory via timeout.

Parameters:
- ADDR_W, 6, block address width shared by all ports.
- DATA_W, 32, block data width.
- TIMEOUT, 31, maximum cycles spent in WAIT before the access is aborted (1..255).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- I_READ  in  1  instruction fetch read request, level, held until I_BUSYWAIT is low.
- I_ADDRESS  in  ADDR_W  fetch block address.
- I_READDATA  out  DATA_W  fetch read data, registered.
- I_BUSYWAIT  out  1  fetch stall.
- D_READ  in  1  data read request, level.
- D_WRITE  in  1  data write request, level.
- D_ADDRESS  in  ADDR_W  data block address.
- D_WRITEDATA  in  DATA_W  data write block.
- D_READDATA  out  DATA_W  data read data, registered.
- D_BUSYWAIT  out  1  data stall.
- MEM_READ  out  1  memory read strobe, registered.
- MEM_WRITE  out  1  memory write strobe, registered.
- MEM_ADDRESS  out  ADDR_W  memory address, registered.
- MEM_WRITEDATA  out  DATA_W  memory write data, registered.
- MEM_READDATA  in  DATA_W  memory read data.
- MEM_BUSYWAIT  in  1  memory busy.
- ERROR  out  1  sticky timeout flag.

Behaviour:
- Reset (asynchronous, active-high):
  - State = IDLE, owner = none, timeout counter = 0.
  - MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, I_READDATA, D_READDATA and ERROR all = 0.
- Busywait outputs are combinational:
  - I_BUSYWAIT = I_READ & ~(state==RELEASE & owner==I).
  - D_BUSYWAIT = (D_READ|D_WRITE) & ~(state==RELEASE & owner==D).
- IDLE:
  - No grant while MEM_BUSYWAIT=1 (protects a memory still finishing an op aborted by reset or timeout).
  - Otherwise, if a D request is pending, grant D; else if I_READ, grant I.
  - On grant: latch address and write data, set the MEM strobe, go to ISSUE.
  - D_READ and D_WRITE both high: write wins, the read is ignored.
- ISSUE (1 cycle): strobes held. Memory must raise MEM_BUSYWAIT within this cycle. Go to WAIT and clear the counter.
- WAIT:
  - Strobes held; the counter increments each cycle.
  - At the first rising edge with MEM_BUSYWAIT=0: latch MEM_READDATA into the owner's READDATA (reads only), drop the strobes, go to RELEASE.
  - If the counter reaches TIMEOUT: set ERROR, drop the strobes, leave READDATA unchanged, go to RELEASE.
- RELEASE (exactly 1 cycle): the owner's busywait is low and its READDATA is valid. Next state IDLE; a held request is re-arbitrated as a new access.
- Latency, unloaded read with memory busy for N cycles: request to busywait-low takes N+2 cycles (ISSUE, N WAIT cycles, RELEASE).
- Requester address or data changes after grant are ignored until the next grant.
- A request dropped mid-service still completes on the memory side; the result is discarded.
- Non-owner requests stay stalled; both requesters may be stalled at once.
- Reset mid-access:
  - Strobes drop immediately.
  - The returned data is discarded.
  - The IDLE guard then waits for MEM_BUSYWAIT=0 before any new grant.
- ERROR clears only on RESET.

Optional Feature:
- Macro ROUND_ROBIN_EN.
- Defined: a priority bit toggles after each completed or timed-out access. When both requesters are pending in IDLE, the requester not served last wins. The priority bit resets to favour D.
- Undefined: fixed priority, D always beats I, and I can starve under back-to-back data traffic.

Test Plan:
- Fetch read, I_ADDRESS=6'h05, memory busy 5 cycles returning 32'hDEADBEEF -> MEM_READ high 6 cycles, I_READDATA=32'hDEADBEEF, I_BUSYWAIT low 1 cycle, 7 cycles after the request.
- D_WRITE to 6'h12 with 32'h11223344 and I_READ raised in the same cycle -> D served first with MEM_WRITEDATA=32'h11223344; I granted in the IDLE cycle after D's RELEASE; I_BUSYWAIT high throughout D's service.
- D_READ and D_WRITE both high -> only MEM_WRITE asserted, MEM_READ stays 0.
- Memory holds MEM_BUSYWAIT=1 forever, TIMEOUT=31 -> ERROR set after 31 WAIT cycles, requester released; no new grant issued while MEM_BUSYWAIT stays 1.
- RESET pulsed during WAIT of a data read -> strobes 0 immediately, D_READDATA stays 0, next grant only after MEM_BUSYWAIT falls.
- With ROUND_ROBIN_EN, I and D held continuously -> grants alternate D, I, D, I over 4 accesses; without it -> D, D, D, D.
